// File: rtl/e_mdu_pkg.sv
// ---------------------------------------------------------------------------
// e_mdu_pkg -- shared definitions for the E-stage multiply/divide unit.
//
// Holds the md_op encoding, the fixed mult/div latencies and small helper
// functions used by e_mdu and mdu_calc.
//
// Optional feature macro: MDU_MADD_EN
//   defined   -> md_op 7 (madd) and 8 (maddu) are legal accumulate ops
//   undefined -> md_op 7/8 are illegal and never accepted
// ---------------------------------------------------------------------------
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8
  } md_op_e;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int CNT_W       = 4;

  // True for encodings the unit is allowed to accept. MD_NONE is not an op.
  function automatic logic md_op_legal(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO: legal = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic md_op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Busy-cycle count loaded into the down-counter at accept.
  function automatic logic [CNT_W-1:0] md_latency(input md_op_e op);
    return md_op_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// ---------------------------------------------------------------------------
// mdu_calc -- purely combinational 64-bit result generator for the MDU.
//
// Ports:
//   op      in   md_op_e  latched operation
//   a       in   32       latched rs operand
//   b       in   32       latched rt operand
//   acc     in   64       current {HI,LO}, used as accumulator and as the
//                         pass-through value for ops that do not write
//   result  out  64       {HI,LO} value to commit
//
// Optional feature macro: MDU_MADD_EN (enables madd/maddu accumulation).
// ---------------------------------------------------------------------------
module mdu_calc
  import e_mdu_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] acc,
  output logic [63:0] result
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        divisor;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  // Sign-extend to 64 bits so the signed product is exact.
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // A zero divisor never commits; substitute 1 so the divider stays defined.
  assign divisor = (b == 32'd0) ? 32'd1 : b;

  // SV signed division truncates toward zero and the remainder takes the
  // sign of the dividend, which is the MIPS div behaviour.
  assign quot_s = $signed(a) / $signed(divisor);
  assign rem_s  = $signed(a) % $signed(divisor);
  assign quot_u = a / divisor;
  assign rem_u  = a % divisor;

  always_comb begin
    result = acc;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {rem_s, quot_s};
      MD_DIVU:  result = {rem_u, quot_u};
`ifdef MDU_MADD_EN
      MD_MADD:  result = acc + prod_s;
      MD_MADDU: result = acc + prod_u;
`endif
      default:  result = acc;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu -- E-stage multiply/divide unit with architectural HI/LO.
//
// Ports:
//   clk      in   1   system clock
//   rst      in   1   synchronous active-high reset
//   req      in   1   M-stage flush; blocks accepting a new op
//   start    in   1   E-stage instruction is an MDU op
//   md_op    in   4   operation encoding (see e_mdu_pkg::md_op_e)
//   rs_data  in   32  rs operand
//   rt_data  in   32  rt operand
//   busy     out  1   registered, high while a mult/div is in flight
//   hi       out  32  architectural HI
//   lo       out  32  architectural LO
//
// Mult-class ops stay busy for MULT_CYCLES, div-class for DIV_CYCLES; HI/LO
// are written only on the edge where busy falls. mthi/mtlo write directly.
//
// Optional feature macro: MDU_MADD_EN (madd/maddu accumulate into {HI,LO}).
// ---------------------------------------------------------------------------
module e_mdu
  import e_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [CNT_W-1:0] cnt;
  md_op_e           op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [63:0]      temp;
  logic [63:0]      calc_result;
  logic             accept;
  logic             commit_ok;
  md_op_e           op_in;

  assign op_in  = md_op_e'(md_op);
  assign accept = start && !busy && !req && md_op_legal(md_op);

  // Divide by zero runs the full latency but leaves HI/LO untouched.
  assign commit_ok = !(md_op_is_div(op_q) && (b_q == 32'd0));

  mdu_calc u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .acc    ({hi, lo}),
    .result (calc_result)
  );

  // Operands are frozen at accept and temp tracks the result on every busy
  // cycle before the last one, so the commit edge copies a settled value.
  // HI/LO cannot change while busy, so accumulating ops see the same
  // {HI,LO} here as they would at commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      temp <= '0;
      hi   <= '0;
      lo   <= '0;
      op_q <= MD_NONE;
      a_q  <= '0;
      b_q  <= '0;
    end else if (busy) begin
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        cnt  <= '0;
        if (commit_ok) begin
          {hi, lo} <= temp;
        end
      end else begin
        cnt  <= cnt - CNT_W'(1);
        temp <= calc_result;
      end
    end else if (accept) begin
      case (op_in)
        MD_MTHI: hi <= rs_data;
        MD_MTLO: lo <= rs_data;
        default: begin
          op_q <= op_in;
          a_q  <= rs_data;
          b_q  <= rt_data;
          cnt  <= md_latency(op_in);
          busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu -- self-checking bench for e_mdu.
//
// Directed ops push their expected {busy cycles, HI, LO} into a queue; an
// independent monitor pops an entry each time busy falls and compares.
// Ops that never raise busy are checked inline. Honours MDU_MADD_EN.
// ---------------------------------------------------------------------------
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    string       name;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          total;
  int          bad;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .start   (start),
    .md_op   (md_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // Drive one op for a single cycle, then scramble the operands so a design
  // that fails to latch them produces a wrong result. Returns at the
  // negedge right after the accepting edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic r);
    @(negedge clk);
    start   = 1'b1;
    md_op   = op;
    rs_data = a;
    rt_data = b;
    req     = r;
    @(negedge clk);
    start   = 1'b0;
    md_op   = 4'd0;
    req     = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) checkOutput({name, "_timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic runOp(input string name, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int cycles, input logic [31:0] eh,
                       input logic [31:0] el);
    sb.push_back('{name: name, cycles: cycles, hi: eh, lo: el});
    applyStimulus(op, a, b, 1'b0);
    checkOutput({name, "_busy_rise"}, 64'(busy), 64'd1);
    checkOutput({name, "_hi_held"}, 64'(hi), 64'(m_hi));
    checkOutput({name, "_lo_held"}, 64'(lo), 64'(m_lo));
    waitIdle(name);
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic runNoAccept(input string name, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic r);
    applyStimulus(op, a, b, r);
    checkOutput({name, "_busy"}, 64'(busy), 64'd0);
    checkOutput({name, "_hi"}, 64'(hi), 64'(m_hi));
    checkOutput({name, "_lo"}, 64'(lo), 64'(m_lo));
  endtask

  // Monitor: counts busy cycles and scores each completion against the queue.
  initial begin
    int   cnt;
    logic prev;
    exp_t e;
    cnt  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        cnt++;
      end else if (prev) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_completion", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput({e.name, "_cycles"}, 64'(cnt), 64'(e.cycles));
          checkOutput({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          checkOutput({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        end
        cnt = 0;
      end
      prev = (busy === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total   = 0;
    bad     = 0;
    m_hi    = 32'd0;
    m_lo    = 32'd0;
    rst     = 1'b1;
    req     = 1'b0;
    start   = 1'b0;
    md_op   = 4'd0;
    rs_data = 32'd0;
    rt_data = 32'd0;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    rst = 1'b0;

    runOp("mult_neg1x2", MD_MULT, 32'hFFFF_FFFF, 32'd2, 5,
          32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runOp("multu_maxx2", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5,
          32'h0000_0001, 32'hFFFF_FFFE);
    runOp("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10,
          32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu_by0", MD_DIVU, 32'd1234, 32'd0, 10, m_hi, m_lo);
    runOp("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 10,
          32'h0000_0001, 32'hFFFF_FFFD);
    runOp("divu_100_7", MD_DIVU, 32'd100, 32'd7, 10,
          32'h0000_0002, 32'h0000_000E);

    runNoAccept("mthi_req", MD_MTHI, 32'h1234_5678, 32'd0, 1'b1);
    applyStimulus(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    m_hi = 32'h1234_5678;
    checkOutput("mthi_busy", 64'(busy), 64'd0);
    checkOutput("mthi_hi", 64'(hi), 64'(m_hi));
    applyStimulus(MD_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    m_lo = 32'hCAFE_F00D;
    checkOutput("mtlo_busy", 64'(busy), 64'd0);
    checkOutput("mtlo_lo", 64'(lo), 64'(m_lo));
    runNoAccept("op_none", MD_NONE, 32'h5, 32'h5, 1'b0);
    runNoAccept("op_illegal9", 4'd9, 32'h5, 32'h5, 1'b0);
    runNoAccept("mult_req", MD_MULT, 32'h5, 32'h5, 1'b1);

    applyStimulus(MD_MTHI, 32'h0000_0000, 32'd0, 1'b0);
    applyStimulus(MD_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
    m_hi = 32'h0000_0000;
    m_lo = 32'hFFFF_FFFF;
`ifdef MDU_MADD_EN
    runOp("maddu_1x1", MD_MADDU, 32'd1, 32'd1, 5, 32'h0000_0001, 32'h0000_0000);
    runOp("madd_m1x1", MD_MADD, 32'hFFFF_FFFF, 32'd1, 5,
          32'h0000_0000, 32'hFFFF_FFFF);
`else
    runNoAccept("maddu_off", MD_MADDU, 32'd1, 32'd1, 1'b0);
    runNoAccept("madd_off", MD_MADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
`endif

    // req raised while a mult is in flight must not cancel it.
    sb.push_back('{name: "mult_req_busy", cycles: 5, hi: 32'd0, lo: 32'd12});
    applyStimulus(MD_MULT, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    req = 1'b1;
    waitIdle("mult_req_busy");
    req  = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd12;

    // A second start during a div is dropped, not queued.
    sb.push_back('{name: "div_start_busy", cycles: 10, hi: 32'd2, lo: 32'd14});
    applyStimulus(MD_DIV, 32'd100, 32'd7, 1'b0);
    @(negedge clk);
    start   = 1'b1;
    md_op   = MD_MULT;
    rs_data = 32'd5;
    rt_data = 32'd5;
    @(negedge clk);
    start = 1'b0;
    md_op = 4'd0;
    waitIdle("div_start_busy");
    m_hi = 32'd2;
    m_lo = 32'd14;
    @(negedge clk);
    checkOutput("no_queue_busy", 64'(busy), 64'd0);
    checkOutput("no_queue_lo", 64'(lo), 64'(m_lo));

    // Reset asserted during the third busy cycle discards the div.
    sb.push_back('{name: "rst_abort", cycles: 3, hi: 32'd0, lo: 32'd0});
    applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    checkOutput("rst_mid_hi", 64'(hi), 64'd0);
    checkOutput("rst_mid_lo", 64'(lo), 64'd0);
    repeat (15) @(negedge clk);
    checkOutput("rst_late_hi", 64'(hi), 64'd0);
    checkOutput("rst_late_lo", 64'(lo), 64'd0);

    // Reset wins over a simultaneous mtlo accept.
    @(negedge clk);
    rst     = 1'b1;
    start   = 1'b1;
    md_op   = MD_MTLO;
    rs_data = 32'hAAAA_5555;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    md_op = 4'd0;
    checkOutput("rst_prio_lo", 64'(lo), 64'd0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Reset rst, synchronous, active-high; clock clk; all state changes on posedge clk only.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req  input  1  exception/interrupt flush from M stage; high means the current E instruction is cancelled.
REQ-005 start  input  1  E-stage instruction is an MDU op (qualified by md_op).
REQ-006 md_op  input  4  encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu.
REQ-007 rs_data  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source).
REQ-008 rt_data  input  32  forwarded rt operand (divisor / multiplier).
REQ-009 busy  output  1  registered; high while a mult/div is in flight.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register; hi/lo feed E_HL_data for mfhi/mflo.

Function
REQ-012 An op SHALL be accepted only when start=1, busy=0, req=0 and md_op is legal; otherwise no state changes.
REQ-013 mult/multu/madd/maddu: busy rises on the accepting edge and stays high exactly 5 cycles; div/divu: exactly 10 cycles.
REQ-014 HI/LO SHALL update on the edge where busy falls, never earlier; intermediate result held in internal 64-bit temp register.
REQ-015 mult: {HI,LO} = signed 32x32 -> 64 product; multu: unsigned product.
REQ-016 div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned.
REQ-017 div/divu with rt_data=0: busy SHALL still run 10 cycles; HI/LO unchanged.
REQ-018 mthi/mtlo: HI (resp. LO) <= rs_data on the accepting edge; busy stays 0.
REQ-019 start while busy=1 SHALL be ignored (hazard unit stalls on start|busy); no queuing.
REQ-020 req asserted while busy=1 SHALL NOT cancel the in-flight op (already committed); it only blocks a new accept.
REQ-021 Operands latched at accept; later changes on rs_data/rt_data have no effect on the in-flight op.
REQ-022 Internal down-counter loaded with latency, decremented while busy; commit and clear busy when counter reaches 1.

Reset
REQ-023 rst SHALL clear hi, lo, temp, counter and busy to 0 on the next edge, including mid-operation (in-flight result discarded).
REQ-024 rst has priority over accept, commit and req.

Configuration
REQ-025 MDU_MADD_EN defined: md_op 7 (madd) computes {HI,LO} + signed product, 8 (maddu) {HI,LO} + unsigned product, both modulo 2^64, HI/LO sampled at commit, 5-cycle latency.
REQ-026 MDU_MADD_EN undefined: md_op 7/8 treated as illegal (not accepted, busy stays 0, HI/LO unchanged).

Structure
REQ-027 Shared package/header holds md_op encodings and latency constants MULT_CYCLES=5, DIV_CYCLES=10.
REQ-028 One combinational sub-module mdu_calc computes the 64-bit result from op and latched operands; e_mdu owns counter, busy, temp, HI/LO.

Verification
REQ-029 mult rs=0xFFFFFFFF rt=2 -> busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE.
REQ-030 multu rs=0xFFFFFFFF rt=2 -> HI=0x00000001 LO=0xFFFFFFFE after 5 cycles.
REQ-031 div rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF; divu rt=0 -> 10 busy cycles, HI/LO unchanged.
REQ-032 mthi rs=0x12345678 with req=1 -> HI unchanged, busy 0; same with req=0 -> HI=0x12345678 next edge, no busy.
REQ-033 div accepted, rst at 3rd busy cycle -> next edge busy=0 HI=LO=0, no later commit; start during busy -> ignored.
REQ-034 MDU_MADD_EN: HI=0 LO=0xFFFFFFFF, maddu rs=1 rt=1 -> HI=0x00000001 LO=0x00000000; without macro -> no accept.
